// File: rtl/konami_rcfilt_mixer_pkg.sv
// Shared types and constants for the Konami sound mixer blocks.
package konami_snd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_UPD,
    ST_ACC,
    ST_SAT
  } snd_state_e;

  // Filter select codes (AY port-B capacitor selection)
  localparam logic [1:0] SEL_BYPASS = 2'd0;
  localparam logic [1:0] SEL_47NF   = 2'd1;
  localparam logic [1:0] SEL_220NF  = 2'd2;
  localparam logic [1:0] SEL_267NF  = 2'd3;

  localparam int COEF_CW = 14;

  // alpha * 2^14 per select code; code 0 never reaches the filter maths
  localparam logic [3:0][COEF_CW:0] COEF_DEFAULT = {15'h01A0, 15'h0200, 15'h0800, 15'h4000};

  // Clamp a signed value (up to 32 bits) into the range of an ow-bit signed word (ow < 32).
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int ow);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (ow - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (ow - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/konami_rcfilt_mixer_saturate.sv
// Parametrised signed clamp with clip detect; purely combinational.
module snd_saturate
  import konami_snd_pkg::*;
#(
  parameter int IW = 21,
  parameter int OW = 16
)(
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 clamp
);

  logic signed [31:0] wide;
  logic signed [31:0] clamped;

  assign wide    = 32'(din);
  assign clamped = sat(wide, OW);
  assign dout    = OW'(clamped);
  assign clamp   = (clamped != wide);

endmodule

// File: rtl/konami_rcfilt_mixer.sv
// Time-multiplexed RC low-pass + gain mixer: one multiplier walks the channels,
// accumulates, then saturates to a single output sample.
module konami_rcfilt_mixer
  import konami_snd_pkg::*;
#(
  parameter int CH = 4,
  parameter int IW = 16,
  parameter int OW = 16,
  parameter int CW = 14,
  parameter logic [3:0][CW:0] COEF = COEF_DEFAULT
)(
  input  logic                 clk_49m,
  input  logic                 rst,
  input  logic                 sample_cen,
  input  logic [CH*IW-1:0]     ch_in,
  input  logic [CH*2-1:0]      ch_sel,
  input  logic [CH*8-1:0]      ch_gain,
  output logic signed [OW-1:0] sound,
  output logic                 sound_valid,
  output logic                 busy,
  output logic                 clip,
  output logic                 overrun
);

  localparam int IDXW = $clog2(CH);
  localparam int YW   = IW + 1;                       // filter state
  localparam int DW   = IW + 2;                       // x - y
  localparam int AW   = IW + $clog2(CH) + 3;          // accumulator
  localparam int MBW  = (CW + 2 > 9) ? CW + 2 : 9;    // coef or gain, sign bit added
  localparam int PW   = DW + MBW;                     // multiplier product
  localparam int GPW  = YW + 2;                       // (y * gain) >>> 7

  snd_state_e state_q, state_d;
  logic [IDXW-1:0] idx;

  logic [CH-1:0][IW-1:0] x_q;
  logic [CH-1:0][1:0]    sel_q;
  logic [CH-1:0][7:0]    gain_q;
  logic signed [YW-1:0]  y_q [CH];

  logic signed [PW-1:0]  prod_q;
  logic signed [GPW-1:0] gp_q;
  logic signed [AW-1:0]  acc_q;

  logic signed [IW-1:0]  cur_x;
  logic signed [YW-1:0]  cur_y;
  logic signed [YW-1:0]  y_new;
  logic [1:0]            cur_sel;
  logic [7:0]            cur_gain;
  logic signed [DW-1:0]  diff;
  logic signed [DW-1:0]  mul_a;
  logic signed [MBW-1:0] mul_b;
  logic signed [PW-1:0]  mul_p;
  logic signed [GPW-1:0] gp_d;
  logic signed [OW-1:0]  sat_val;
  logic                  sat_clamp;
  logic                  last_ch;

  assign cur_x    = x_q[idx];
  assign cur_y    = y_q[idx];
  assign cur_sel  = sel_q[idx];
  assign cur_gain = gain_q[idx];
  assign last_ch  = (idx == IDXW'(CH - 1));
  assign busy     = (state_q != ST_IDLE);

  assign diff  = DW'(cur_x) - DW'(cur_y);
  // Bypass loads the input directly; otherwise step by the registered filter product
  assign y_new = (cur_sel == SEL_BYPASS) ? YW'(cur_x) : cur_y + YW'(prod_q >>> CW);
  assign gp_d  = GPW'(mul_p >>> 7);

  // Single multiplier: filter step in MUL, channel gain in UPD
  always_comb begin
    mul_a = diff;
    mul_b = MBW'({1'b0, COEF[cur_sel]});
    if (state_q == ST_UPD) begin
      mul_a = DW'(y_new);
      mul_b = MBW'({1'b0, cur_gain});
    end
    mul_p = PW'(mul_a) * PW'(mul_b);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (sample_cen) state_d = ST_MUL;
      ST_MUL:  state_d = ST_UPD;
      ST_UPD:  state_d = ST_ACC;
      ST_ACC:  state_d = last_ch ? ST_SAT : ST_MUL;
      ST_SAT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_49m or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Input snapshot and channel index
  always_ff @(posedge clk_49m or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      sel_q  <= '0;
      gain_q <= '0;
      idx    <= '0;
    end else if (state_q == ST_IDLE && sample_cen) begin
      x_q    <= ch_in;
      sel_q  <= ch_sel;
      gain_q <= ch_gain;
      idx    <= '0;
    end else if (state_q == ST_ACC && !last_ch) begin
      idx    <= idx + IDXW'(1);
    end
  end

  // Filter state array; only rst clears it
  always_ff @(posedge clk_49m or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) y_q[i] <= '0;
    end else if (state_q == ST_UPD) begin
      y_q[idx] <= y_new;
    end
  end

  // Product, gained sample and accumulator
  always_ff @(posedge clk_49m or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      gp_q   <= '0;
      acc_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (sample_cen) acc_q <= '0;
        ST_MUL:  prod_q <= mul_p;
        ST_UPD:  gp_q   <= gp_d;
        ST_ACC:  acc_q  <= acc_q + AW'(gp_q);
        default: ;
      endcase
    end
  end

  snd_saturate #(.IW(AW), .OW(OW)) u_sat (
    .din   (acc_q),
    .dout  (sat_val),
    .clamp (sat_clamp)
  );

  // Registered outputs: sample, valid pulse, sticky clip, overrun pulse
  always_ff @(posedge clk_49m or posedge rst) begin
    if (rst) begin
      sound       <= '0;
      sound_valid <= 1'b0;
      clip        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sound_valid <= 1'b0;
      overrun     <= sample_cen && (state_q != ST_IDLE);
      if (state_q == ST_SAT) begin
        sound       <= sat_val;
        sound_valid <= 1'b1;
        if (sat_clamp) clip <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_konami_rcfilt_mixer.sv
// Directed bench for konami_rcfilt_mixer (CH=4, IW=OW=16, CW=14).
module tb_konami_rcfilt_mixer;

  logic               clk_49m = 1'b0;
  logic               rst = 1'b1;
  logic               sample_cen = 1'b0;
  logic [63:0]        ch_in = '0;
  logic [7:0]         ch_sel = '0;
  logic [31:0]        ch_gain = '0;
  logic signed [15:0] sound;
  logic               sound_valid, busy, clip, overrun;

  int checks = 0;
  int errors = 0;

  konami_rcfilt_mixer #(.CH(4), .IW(16), .OW(16), .CW(14)) dut (
    .clk_49m     (clk_49m),
    .rst         (rst),
    .sample_cen  (sample_cen),
    .ch_in       (ch_in),
    .ch_sel      (ch_sel),
    .ch_gain     (ch_gain),
    .sound       (sound),
    .sound_valid (sound_valid),
    .busy        (busy),
    .clip        (clip),
    .overrun     (overrun)
  );

  always #5 clk_49m = ~clk_49m;

  task automatic set_ch(input int i, input int x, input logic [1:0] s, input logic [7:0] g);
    ch_in[i*16 +: 16] = 16'(x);
    ch_sel[i*2 +: 2]  = s;
    ch_gain[i*8 +: 8] = g;
  endtask

  task automatic set_all(input int x0, input int x1, input int x2, input int x3,
                         input logic [1:0] s0, input logic [7:0] g);
    set_ch(0, x0, s0, g);
    set_ch(1, x1, 2'd0, g);
    set_ch(2, x2, 2'd0, g);
    set_ch(3, x3, 2'd0, g);
  endtask

  // Strobe one sample; lat = cycle index of sound_valid, strobe cycle being 0.
  // held_ok drops if sound moves before the valid pulse.
  task automatic run_sample(output logic signed [15:0] res, output int lat, output bit held_ok);
    logic signed [15:0] prev;
    res = '0; lat = 0; held_ok = 1'b1;
    prev = sound;
    sample_cen = 1'b1;
    @(posedge clk_49m); #1;
    sample_cen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (sound_valid) begin
        lat = c; res = sound;
        break;
      end
      if (sound !== prev) held_ok = 1'b0;
      @(posedge clk_49m); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_49m);
    #1;
    checks++; if (sound !== 16'sd0)    begin errors++; $display("FAIL reset_sound got %0d exp 0", sound); end
    checks++; if (sound_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", sound_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (clip !== 1'b0)       begin errors++; $display("FAIL reset_clip got %b exp 0", clip); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    rst = 1'b0;
    @(posedge clk_49m); #1;
  endtask

  task automatic test_bypass();
    logic signed [15:0] r; int lat; bit held;
    set_all(1000, 2000, -500, 0, 2'd0, 8'h80);
    run_sample(r, lat, held);
    checks++; if (lat != 14)       begin errors++; $display("FAIL bypass_latency got %0d exp 14", lat); end
    checks++; if (r !== 16'sd2500) begin errors++; $display("FAIL bypass_sound got %0d exp 2500", r); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL bypass_busy_end got %b exp 0", busy); end
    @(posedge clk_49m); #1;
    checks++; if (sound_valid !== 1'b0) begin errors++; $display("FAIL bypass_pulse_width got %b exp 0", sound_valid); end
    checks++; if (sound !== 16'sd2500)  begin errors++; $display("FAIL bypass_hold got %0d exp 2500", sound); end
  endtask

  task automatic test_overrun();
    int nvalid = 0; int lat = 0; bit ov_hit = 0; bit ov_after = 1;
    logic signed [15:0] r = '0;
    set_all(1000, 2000, -500, 0, 2'd0, 8'h80);
    sample_cen = 1'b1;
    @(posedge clk_49m); #1;
    sample_cen = 1'b0;
    for (int c = 1; c < 30; c++) begin
      if (c == 5) begin
        sample_cen = 1'b1;
        set_all(7, 7, 7, 7, 2'd0, 8'h80);
      end
      @(posedge clk_49m); #1;
      sample_cen = 1'b0;
      if (c + 1 == 6) ov_hit   = overrun;
      if (c + 1 == 7) ov_after = overrun;
      if (sound_valid) begin nvalid++; lat = c + 1; r = sound; end
    end
    checks++; if (ov_hit !== 1'b1)   begin errors++; $display("FAIL overrun_pulse got %b exp 1", ov_hit); end
    checks++; if (ov_after !== 1'b0) begin errors++; $display("FAIL overrun_width got %b exp 0", ov_after); end
    checks++; if (nvalid != 1)       begin errors++; $display("FAIL overrun_valid_count got %0d exp 1", nvalid); end
    checks++; if (lat != 14)         begin errors++; $display("FAIL overrun_latency got %0d exp 14", lat); end
    checks++; if (r !== 16'sd2500)   begin errors++; $display("FAIL overrun_sound got %0d exp 2500", r); end
  endtask

  // Bypass an all-zero sample so every filter state returns to 0
  task automatic test_flush();
    logic signed [15:0] r; int lat; bit held;
    set_all(0, 0, 0, 0, 2'd0, 8'h80);
    run_sample(r, lat, held);
    checks++; if (r !== 16'sd0) begin errors++; $display("FAIL flush_sound got %0d exp 0", r); end
  endtask

  task automatic test_step();
    logic signed [15:0] r; int lat; bit held;
    int exp_s [3] = '{1000, 1875, 2640};
    set_all(8000, 0, 0, 0, 2'd1, 8'h80);
    for (int k = 0; k < 3; k++) begin
      run_sample(r, lat, held);
      checks++; if (r !== 16'(exp_s[k])) begin errors++; $display("FAIL step_%0d got %0d exp %0d", k, r, exp_s[k]); end
      checks++; if (lat != 14)           begin errors++; $display("FAIL step_latency_%0d got %0d exp 14", k, lat); end
    end
  endtask

  task automatic test_select_change();
    logic signed [15:0] r; int lat; bit held;
    set_all(8000, 0, 0, 0, 2'd0, 8'h80);
    run_sample(r, lat, held);
    checks++; if (held !== 1'b1)    begin errors++; $display("FAIL selchg_hold got %b exp 1", held); end
    checks++; if (r !== 16'sd8000)  begin errors++; $display("FAIL selchg_sound got %0d exp 8000", r); end
  endtask

  task automatic test_saturation();
    logic signed [15:0] r; int lat; bit held;
    set_all(30000, 30000, 30000, 30000, 2'd0, 8'hFF);
    run_sample(r, lat, held);
    checks++; if (r !== 16'sd32767) begin errors++; $display("FAIL sat_pos got %0d exp 32767", r); end
    checks++; if (clip !== 1'b1)    begin errors++; $display("FAIL sat_pos_clip got %b exp 1", clip); end
    set_all(-30000, -30000, -30000, -30000, 2'd0, 8'hFF);
    run_sample(r, lat, held);
    checks++; if (r !== 16'(-32768)) begin errors++; $display("FAIL sat_neg got %0d exp -32768", r); end
    checks++; if (clip !== 1'b1)     begin errors++; $display("FAIL sat_neg_clip got %b exp 1", clip); end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] r; int lat; bit held; int nvalid = 0;
    set_all(8000, 0, 0, 0, 2'd1, 8'h80);
    sample_cen = 1'b1;
    @(posedge clk_49m); #1;
    sample_cen = 1'b0;
    for (int c = 1; c < 6; c++) begin
      @(posedge clk_49m); #1;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (sound !== 16'sd0)     begin errors++; $display("FAIL rstmid_sound got %0d exp 0", sound); end
    checks++; if (sound_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", sound_valid); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (clip !== 1'b0)        begin errors++; $display("FAIL rstmid_clip got %b exp 0", clip); end
    checks++; if (overrun !== 1'b0)     begin errors++; $display("FAIL rstmid_overrun got %b exp 0", overrun); end
    repeat (2) @(posedge clk_49m);
    #1; rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_49m); #1;
      if (sound_valid) nvalid++;
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL rstmid_no_valid got %0d exp 0", nvalid); end
    run_sample(r, lat, held);
    checks++; if (r !== 16'sd1000) begin errors++; $display("FAIL rstmid_restart got %0d exp 1000", r); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_overrun();
    test_flush();
    test_step();
    test_select_change();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
